uart_rx_os16: RTL
=================

Name: uart_rx_os16

Overview:
- UART receiver, 8N1, 16x oversampled, with majority-vote bit sampling and framing/overrun detection.
- Standalone receive path that pairs with the existing transmitter at the other end of the serial line.
- Verified by looping the transmitter's out_signal into in_signal.
- Exposes a status/flag interface (out_RXNE, in_RXNE_clear, out_Rx_ORE) plus a framing-error flag.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD, 115200, line bit rate
OVERSAMPLE, 16, sample ticks per bit; fixed at 16, other values unsupported
DIV, CLK_FREQ/(BAUD*OVERSAMPLE), clocks per tick, truncated (54 at defaults); must be >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_signal  in  1  asynchronous serial line, idle high
out_word  out  8  last accepted received byte
out_RXNE  out  1  receive-register-not-empty flag
in_RXNE_clear  in  1  one-cycle pulse: consumer has read out_word
out_Rx_ORE  out  1  overrun error flag
out_Rx_FE  out  1  framing error flag for the byte in out_word
out_busy  out  1  high while a frame is being received (state != IDLE)

Behaviour:
- Reset values: out_word=0, out_RXNE=0, out_Rx_ORE=0, out_Rx_FE=0, out_busy=0. Synchronizer flops reset to 1; tick counter to 0; state to IDLE.
- Input sync: 2-flop synchronizer on in_signal; all logic uses the synced bit s_rx. Input-to-s_rx latency is 2 clocks.
- Tick generator:
  - Counter runs 0..DIV-1 and emits a 1-clk tick at DIV-1.
  - Counter is forced to 0 on the IDLE->START transition, so ticks are phase-aligned to the start edge.
- Sample counter: 4 bits (0..15), advances on each tick and wraps 15->0. Bit value = majority of s_rx at sample counts 7, 8, 9.
- FSM states:
  - IDLE: wait for falling edge of s_rx (prev=1, now=0), then go to START.
  - START: at sample 9, evaluate the majority.
    - Majority 1 is a glitch: go to IDLE with no flags changed.
    - Majority 0: at sample 15, go to DATA with bit index 0.
  - DATA: 8 bits, LSB first, shifted into a shift register. At sample 15 of bit 7, go to STOP.
  - STOP: at sample 9, evaluate the stop bit and commit (see below), then go to IDLE.
    - If the stop bit was 0 (break/FE case), go to WAIT_HIGH instead of IDLE.
  - WAIT_HIGH: stay until s_rx=1, then go to IDLE. Prevents false starts during a break.
- Commit occurs in the STOP sample-9 cycle; this is about 9.5 bit times after the start edge.
  - If out_RXNE=0, or in_RXNE_clear=1 in the same cycle:
    - out_word <= shift register; out_RXNE <= 1.
    - out_Rx_FE <= (stop majority == 0).
  - If out_RXNE=1 and in_RXNE_clear=0:
    - New byte discarded; out_word and out_Rx_FE keep their old values.
    - out_Rx_ORE <= 1.
- in_RXNE_clear with no commit in the same cycle: out_RXNE, out_Rx_ORE and out_Rx_FE all go to 0 next cycle. Clear while out_RXNE=0 has no effect.
- out_busy = 1 in START, DATA and STOP; 0 in IDLE and WAIT_HIGH.
- Reset mid-frame: abort immediately; all state and flags return to reset values, and the partial byte is lost.
- Back-to-back frames: a start edge arriving directly after the stop bit is detected, because IDLE is re-entered before the end of the stop bit.

Test Plan:
- Loopback 0x36 at default params (bit = 864 clks) -> out_RXNE rises ~8208 clks after the start edge; out_word=0x36; FE=0; ORE=0.
- Two back-to-back frames 0x36, 0x78, with in_RXNE_clear pulsed after the first -> out_word=0x36 then 0x78; ORE never set.
- Two frames 0x36, 0x78 with no clear -> out_word stays 0x36; out_RXNE=1; out_Rx_ORE=1 after the second frame; clear pulse -> all flags 0.
- Start glitch: line low for 300 clks (< half bit), then high -> state returns to IDLE; out_RXNE stays 0; out_busy pulses only.
- Frame 0x55 with stop bit driven 0, line held low 3 bit times then high -> out_word=0x55; RXNE=1; FE=1; no second frame detected until the line is high.
- rst asserted at data bit 4 of 0xA5, then a clean 0xC3 frame -> flags 0 after rst; only 0xC3 received.

Source files
------------

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling and 2-of-3 majority voting at the bit centre.
// Holds one received byte behind out_RXNE and reports overrun and framing errors.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | line idle, waiting for a falling edge on s_rx
// START     | qualifying the start bit (glitch rejection at sample 9)
// DATA      | shifting in 8 data bits, LSB first
// STOP      | sampling the stop bit and committing the byte at sample 9
// WAIT_HIGH | stop bit was low (break); hold off until the line is high
module uart_rx_os16 #(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 115200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_signal,
   output logic [7:0] out_word,
   output logic       out_RXNE,
   input  logic       in_RXNE_clear,
   output logic       out_Rx_ORE,
   output logic       out_Rx_FE,
   output logic       out_busy
);

   localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t         state;
   logic           rx_meta;
   logic           s_rx;
   logic           prev_rx;
   logic [CW-1:0]  tick_cnt;
   logic [3:0]     samp_cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     shreg;
   logic           vote7;
   logic           vote8;

   logic           tick;
   logic           at_s9;
   logic           at_s15;
   logic           maj;
   logic           in_frame;
   logic           commit;

   always_comb begin
      tick     = (tick_cnt == TICK_LAST);
      at_s9    = tick && (samp_cnt == 4'd9);
      at_s15   = tick && (samp_cnt == 4'd15);
      // sample 9 itself is taken live from s_rx
      maj      = (vote7 & vote8) | (vote7 & s_rx) | (vote8 & s_rx);
      in_frame = (state == START) || (state == DATA) || (state == STOP);
      commit   = (state == STOP) && at_s9;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta    <= 1'b1;
         s_rx       <= 1'b1;
         prev_rx    <= 1'b1;
         tick_cnt   <= '0;
         samp_cnt   <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         vote7      <= 1'b1;
         vote8      <= 1'b1;
         state      <= IDLE;
         out_word   <= '0;
         out_RXNE   <= 1'b0;
         out_Rx_ORE <= 1'b0;
         out_Rx_FE  <= 1'b0;
         out_busy   <= 1'b0;
      end else begin
         rx_meta <= in_signal;
         s_rx    <= rx_meta;
         prev_rx <= s_rx;

         if (tick) begin
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end

         if (in_frame && tick) begin
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'd7) vote7 <= s_rx;
            if (samp_cnt == 4'd8) vote8 <= s_rx;
         end

         if (in_RXNE_clear && out_RXNE && !commit) begin
            out_RXNE   <= 1'b0;
            out_Rx_ORE <= 1'b0;
            out_Rx_FE  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (prev_rx && !s_rx) begin
                  state    <= START;
                  tick_cnt <= '0;
                  samp_cnt <= '0;
                  out_busy <= 1'b1;
               end
            end

            START: begin
               if (at_s9 && maj) begin
                  state    <= IDLE;
                  out_busy <= 1'b0;
               end else if (at_s15) begin
                  state   <= DATA;
                  bit_idx <= '0;
               end
            end

            DATA: begin
               if (at_s9) begin
                  shreg <= {maj, shreg[7:1]};
               end
               if (at_s15) begin
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end

            STOP: begin
               if (commit) begin
                  // a pending unread byte wins unless it is being read this cycle
                  if (!out_RXNE || in_RXNE_clear) begin
                     out_word  <= shreg;
                     out_RXNE  <= 1'b1;
                     out_Rx_FE <= ~maj;
                  end else begin
                     out_Rx_ORE <= 1'b1;
                  end
                  state    <= maj ? IDLE : WAIT_HIGH;
                  out_busy <= 1'b0;
               end
            end

            WAIT_HIGH: begin
               if (s_rx) begin
                  state <= IDLE;
               end
            end

            default: begin
               state    <= IDLE;
               out_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
